pic_data_bus_buffer: RTL

Clocked, parametrised successor to the PIC data bus buffer. Sits between the CPU-facing bidirectional data bus and the control / write-read logic. Captures one bus word per write strobe into a small FIFO drained by control logic over a valid/ready handshake. Serves reads through a request/response state machine with timeout, and drives the bus only while read data is valid.

---
 rtl/pic_bus_pkg.sv | 18 +
 rtl/pic_bus_wr_fifo.sv | 67 ++++++
 rtl/pic_data_bus_buffer.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/pic_bus_pkg.sv
// rtl/pic_bus_pkg.sv - shared types and default constants for the PIC data bus buffer
//
// Purpose: read state machine encoding and the default bus width, write FIFO
// depth and read timeout used by pic_data_bus_buffer and pic_bus_wr_fifo.
// Ports: none (package).
package pic_bus_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    DRIVE = 2'd2
  } rd_state_t;

  localparam int DEF_DATA_W     = 8;
  localparam int DEF_FIFO_DEPTH = 4;
  localparam int DEF_RD_TIMEOUT = 16;

endpackage

// File: rtl/pic_bus_wr_fifo.sv
// rtl/pic_bus_wr_fifo.sv - write-word FIFO between the CPU bus and control logic
//
// Purpose: small synchronous FIFO, no fall-through; a pushed word shows up at
// the head one cycle after the push edge. Full + push + pop does both.
// Ports:
//   clk, reset         clock, synchronous active-high reset
//   push, push_data    write request and word; ignored when full unless popping
//   pop                read request; ignored when empty
//   head, valid        oldest word and its presence flag
//   count, full        occupancy and full flag
module pic_bus_wr_fifo #(
  parameter int W     = 9,
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         push,
  input  logic [W-1:0]                 push_data,
  input  logic                         pop,
  output logic [W-1:0]                 head,
  output logic                         valid,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         full
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign valid   = (count != '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop & valid;
  // A pop in the same edge frees the slot, so a full FIFO can still accept.
  assign do_push = push & (~full | do_pop);
  assign head    = mem[rd_ptr];

  // DEPTH is a power of two, so the pointers wrap by natural overflow.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/pic_data_bus_buffer.sv
// rtl/pic_data_bus_buffer.sv - clocked CPU data bus buffer for the PIC
//
// Purpose: captures one bus word per write strobe into a FIFO drained by the
// control logic, and serves reads through an IDLE/REQ/DRIVE state machine with
// a timeout. The bus is driven only in DRIVE.
// Ports:
//   clk, reset                  clock, synchronous active-high reset
//   Ds                          bidirectional CPU data bus
//   A0                          CPU address bit, captured with write data
//   RD_flag, WR_flag            clk-synchronous read / write strobes
//   Ds_from_control             read data from control logic
//   rd_data_valid               Ds_from_control valid this cycle
//   RD_flag_control             read request to control logic
//   rd_timeout                  one-cycle pulse when a read times out
//   wr_valid, wr_data, wr_a0    FIFO head
//   wr_ready                    control accepts the FIFO head
//   Ds_to_W_R                   last captured write word
//   fifo_count                  FIFO occupancy
//   overflow, clr_overflow      sticky dropped-write flag and its clear
module pic_data_bus_buffer
  import pic_bus_pkg::*;
#(
  parameter int                DATA_W       = DEF_DATA_W,
  parameter int                FIFO_DEPTH   = DEF_FIFO_DEPTH,
  parameter int                RD_TIMEOUT   = DEF_RD_TIMEOUT,
  parameter logic [DATA_W-1:0] TIMEOUT_DATA = '1
) (
  input  logic                              clk,
  input  logic                              reset,
  inout  wire  [DATA_W-1:0]                 Ds,
  input  logic                              A0,
  input  logic                              RD_flag,
  input  logic                              WR_flag,
  input  logic [DATA_W-1:0]                 Ds_from_control,
  input  logic                              rd_data_valid,
  output logic                              RD_flag_control,
  output logic                              rd_timeout,
  output logic                              wr_valid,
  output logic [DATA_W-1:0]                 wr_data,
  output logic                              wr_a0,
  input  logic                              wr_ready,
  output logic [DATA_W-1:0]                 Ds_to_W_R,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_count,
  output logic                              overflow,
  input  logic                              clr_overflow
);

  localparam int TW = $clog2(RD_TIMEOUT + 1);

  logic              wr_flag_q;
  logic              rd_flag_q;
  logic              wr_rise;
  logic              rd_rise;
  logic              push;
  logic              pop;
  logic              fifo_full;
  logic [DATA_W:0]   head;
  rd_state_t         state;
  rd_state_t         state_nxt;
  logic [TW-1:0]     timer;
  logic [DATA_W-1:0] rd_data_q;
  logic              take_valid;
  logic              take_timeout;
  logic              ds_oe;

  assign wr_rise = WR_flag & ~wr_flag_q;
  assign rd_rise = RD_flag & ~rd_flag_q;
  // A concurrent read strobe wins: the bus may not hold CPU write data.
  assign push    = wr_rise & ~RD_flag;
  assign pop     = wr_valid & wr_ready;

  pic_bus_wr_fifo #(
    .W     (DATA_W + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_wr_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data ({A0, Ds}),
    .pop       (pop),
    .head      (head),
    .valid     (wr_valid),
    .count     (fifo_count),
    .full      (fifo_full)
  );

  assign wr_a0   = head[DATA_W];
  assign wr_data = head[DATA_W-1:0];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_flag_q <= 1'b0;
      rd_flag_q <= 1'b0;
      Ds_to_W_R <= '0;
      overflow  <= 1'b0;
    end else begin
      wr_flag_q <= WR_flag;
      rd_flag_q <= RD_flag;
      if (push) begin
        Ds_to_W_R <= Ds;
      end
      // A fresh drop outranks a clear in the same cycle.
      if (push & fifo_full & ~pop) begin
        overflow <= 1'b1;
      end else if (clr_overflow) begin
        overflow <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Abort (RD_flag low) beats both valid data and the timeout in REQ.
  always_comb begin
    state_nxt    = state;
    take_valid   = 1'b0;
    take_timeout = 1'b0;
    case (state)
      IDLE: begin
        if (rd_rise) begin
          state_nxt = REQ;
        end
      end
      REQ: begin
        if (!RD_flag) begin
          state_nxt = IDLE;
        end else if (rd_data_valid) begin
          state_nxt  = DRIVE;
          take_valid = 1'b1;
        end else if (timer == TW'(RD_TIMEOUT - 1)) begin
          state_nxt    = DRIVE;
          take_timeout = 1'b1;
        end
      end
      DRIVE: begin
        if (!RD_flag) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    RD_flag_control = (state == REQ);
    ds_oe           = (state == DRIVE);
  end

  // Timer counts edges spent in REQ; it is zero on the first REQ cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      timer      <= '0;
      rd_data_q  <= '0;
      rd_timeout <= 1'b0;
    end else begin
      rd_timeout <= take_timeout;
      if (state != REQ) begin
        timer <= '0;
      end else begin
        timer <= timer + TW'(1);
      end
      if (take_valid) begin
        rd_data_q <= Ds_from_control;
      end else if (take_timeout) begin
        rd_data_q <= TIMEOUT_DATA;
      end
    end
  end

  assign Ds = ds_oe ? rd_data_q : {DATA_W{1'bz}};

endmodule
